tdm_demux4: RTL and testbench
=============================

TDM_DEMUX4 -- requirements
Module: tdm_demux4

Purpose: 1-to-4 time-division demultiplexer. It receives a serial slot stream (slot 0..3 per frame, frame_start marks slot 0) and distributes each bit to its channel. It is the receiving end of the team's 4:1 selector path.

Interface
REQ-001 The block SHALL have one clock and one reset: reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock; all state changes on posedge clk.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 din  input  1  serial data bit for the current slot.
REQ-005 din_valid  input  1  din carries a slot bit this cycle.
REQ-006 frame_start  input  1  qualifies din as slot 0 of a new frame; meaningful only with din_valid=1.
REQ-007 ch  output  4  per-channel latched value; ch[k] = last bit accepted in slot k.
REQ-008 ch_strobe  output  4  one-hot, one-cycle pulse; bit k set the cycle after slot k is accepted.
REQ-009 word  output  4  last complete frame, with word[k] = slot k bit.
REQ-010 frame_done  output  1  one-cycle pulse when word updates.
REQ-011 sync_err  output  1  one-cycle pulse when frame_start arrives mid-frame.
REQ-012 All outputs SHALL be registered; there is no combinational path from input to output.

Function
REQ-013 The FSM SHALL have two states: HUNT (awaiting frame start) and RECV (inside a frame). A 2-bit slot counter (slot) SHALL track the next expected slot.
REQ-014 An accepted bit SHALL be defined as din_valid=1 together with the state/frame_start conditions below. Cycles with din_valid=0 SHALL change no state except clearing the pulse outputs.
REQ-015 HUNT, din_valid=1, frame_start=1:
- ch[0] <= din
- ch_strobe <= 4'b0001
- slot <= 1
- next state RECV
REQ-016 HUNT, din_valid=1, frame_start=0: the bit SHALL be discarded, with no output change besides pulse clear.
REQ-017 RECV, din_valid=1, frame_start=0:
- ch[slot] <= din
- ch_strobe <= one-hot(slot)
- slot <= slot+1 (wraps 3->0)
REQ-018 RECV with slot=3 accepted:
- word <= {din, ch[2], ch[1], ch[0]}
- frame_done <= 1
- next state HUNT
REQ-019 RECV, din_valid=1, frame_start=1 (resync):
- sync_err <= 1
- partial frame dropped; word unchanged; no frame_done
- bit accepted as slot 0 (ch[0] <= din, ch_strobe <= 4'b0001, slot <= 1)
- state stays RECV
REQ-020 Latency SHALL be one clock from accepted bit to ch/ch_strobe update. frame_done and word SHALL update in the same cycle as ch_strobe[3].
REQ-021 frame_start with din_valid=0 SHALL be ignored in both states.
REQ-022 ch_strobe, frame_done and sync_err SHALL be 0 in every cycle not specified above.
REQ-023 Back-to-back frames SHALL be supported: a frame_start on the cycle after slot 3 SHALL be accepted from HUNT with no gap cycle.

Reset
REQ-024 While rst=1 the block SHALL hold: state=HUNT, slot=0, ch=0, word=0, ch_strobe=0, frame_done=0, sync_err=0.
REQ-025 rst SHALL take priority over all inputs. Reset mid-frame SHALL discard the partial frame, and no frame_done SHALL follow.
REQ-026 The first cycle after rst deasserts SHALL accept a frame_start bit normally.

Verification
REQ-027 Normal frame: bits 1,0,1,1 in slots 0..3 on consecutive cycles, frame_start on the first -> ch_strobe 0001,0010,0100,1000 on successive cycles; word=4'b1101 and frame_done=1 with the last strobe.
REQ-028 Gapped input: same frame with din_valid=0 for 2 cycles between slots 1 and 2 -> identical word=4'b1101; no strobes during the gaps.
REQ-029 Hunt discard: 3 valid bits without frame_start after reset -> ch=0, no strobe; a subsequent frame 0,1,1,0 -> word=4'b0110.
REQ-030 Resync: frame_start at slot 2 of a frame -> sync_err pulse, ch_strobe=0001, old word retained; a full frame 1,1,1,1 following the resync bit completes with word=4'b1111.
REQ-031 Reset mid-frame: rst=1 after slot 1 -> all outputs 0 next cycle, no frame_done; a new frame is then accepted normally.
REQ-032 Back-to-back: two frames 1010/0101 with no gap -> two frame_done pulses 4 cycles apart; word=4'b0101, then 4'b1010.

Source files
------------

// File: rtl/tdm_demux4_if.sv
// tdm_demux4_if
// Bundles the serial slot stream and the per-channel results of the TDM
// demultiplexer so the block and its driver share one definition.
//
// Signals:
//   din          serial data bit for the current slot
//   din_valid    din carries a slot bit this cycle
//   frame_start  marks din as slot 0 of a new frame (only with din_valid)
//   ch[3:0]      per-channel latched value, ch[k] = last bit taken in slot k
//   ch_strobe    one-hot pulse, bit k set the cycle after slot k is taken
//   word[3:0]    last complete frame, word[k] = slot k bit
//   frame_done   one-cycle pulse when word updates
//   sync_err     one-cycle pulse when a frame start arrives mid-frame
//
// Modports:
//   master  drives the serial stream, observes the channel outputs
//   slave   the demultiplexer itself
interface tdm_demux4_if;
    logic       din;
    logic       din_valid;
    logic       frame_start;
    logic [3:0] ch;
    logic [3:0] ch_strobe;
    logic [3:0] word;
    logic       frame_done;
    logic       sync_err;

    modport master (
        output din, din_valid, frame_start,
        input  ch, ch_strobe, word, frame_done, sync_err
    );

    modport slave (
        input  din, din_valid, frame_start,
        output ch, ch_strobe, word, frame_done, sync_err
    );
endinterface

// File: rtl/tdm_demux4.sv
// tdm_demux4
// 1-to-4 time-division demultiplexer. A serial stream carries four slots per
// frame; frame_start tags slot 0. Each accepted bit is latched into its
// channel, and a completed frame is presented as a 4-bit word. This is the
// receiving end of the 4:1 selector path.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   tdm_demux4_if.slave: din/din_valid/frame_start in,
//         ch/ch_strobe/word/frame_done/sync_err out (all registered)
module tdm_demux4 (
    input  logic          clk,
    input  logic          rst,
    tdm_demux4_if.slave   bus
);

    typedef enum logic {
        HUNT = 1'b0,
        RECV = 1'b1
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] slot_q, slot_d;
    logic [3:0] ch_q, ch_d;
    logic [3:0] chStrobe_q, chStrobe_d;
    logic [3:0] word_q, word_d;
    logic       frameDone_q, frameDone_d;
    logic       syncErr_q, syncErr_d;

    // Every output comes straight from a register, so the cycle after a bit
    // is accepted is when ch/ch_strobe (and word/frame_done for slot 3) show
    // it. Reset wins over all inputs and throws away any partial frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HUNT;
            slot_q      <= 2'd0;
            ch_q        <= 4'd0;
            chStrobe_q  <= 4'd0;
            word_q      <= 4'd0;
            frameDone_q <= 1'b0;
            syncErr_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            ch_q        <= ch_d;
            chStrobe_q  <= chStrobe_d;
            word_q      <= word_d;
            frameDone_q <= frameDone_d;
            syncErr_q   <= syncErr_d;
        end
    end

    // Next-state logic. Pulses default low so they last exactly one cycle;
    // everything else holds unless a valid bit is taken. In HUNT only a
    // tagged slot 0 is taken, anything else is dropped. In RECV a frame_start
    // resynchronises: the partial frame is abandoned (word untouched) and the
    // bit becomes slot 0 of a new frame. Slot 3 closes the frame, builds the
    // word from the three latched channels plus the incoming bit, and drops
    // back to HUNT so a following frame_start is taken with no gap cycle.
    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        ch_d        = ch_q;
        word_d      = word_q;
        chStrobe_d  = 4'd0;
        frameDone_d = 1'b0;
        syncErr_d   = 1'b0;

        if (bus.din_valid) begin
            case (state_q)
                HUNT: begin
                    if (bus.frame_start) begin
                        ch_d[0]    = bus.din;
                        chStrobe_d = 4'b0001;
                        slot_d     = 2'd1;
                        state_d    = RECV;
                    end
                end
                RECV: begin
                    if (bus.frame_start) begin
                        syncErr_d  = 1'b1;
                        ch_d[0]    = bus.din;
                        chStrobe_d = 4'b0001;
                        slot_d     = 2'd1;
                    end else begin
                        ch_d[slot_q] = bus.din;
                        chStrobe_d   = 4'b0001 << slot_q;
                        slot_d       = slot_q + 2'd1;
                        if (slot_q == 2'd3) begin
                            word_d      = {bus.din, ch_q[2:0]};
                            frameDone_d = 1'b1;
                            state_d     = HUNT;
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end
    end

    assign bus.ch         = ch_q;
    assign bus.ch_strobe  = chStrobe_q;
    assign bus.word       = word_q;
    assign bus.frame_done = frameDone_q;
    assign bus.sync_err   = syncErr_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4
// Directed bench for tdm_demux4: reset, a normal frame, back-to-back frames,
// gapped input, hunt discard, resync and reset mid-frame. Expected values are
// worked out by hand for each vector.
module tb_tdm_demux4;

    logic clk = 1'b0;
    logic rst;
    int   testsRun  = 0;
    int   failCount = 0;

    always #5 clk = ~clk;

    tdm_demux4_if bus ();

    tdm_demux4 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Drive one cycle of the serial stream, then settle just past the edge
    // so outputs are sampled well away from the next rising edge.
    task automatic applyStimulus(input logic v, input logic fs, input logic d);
        bus.din_valid   = v;
        bus.frame_start = fs;
        bus.din         = d;
        @(posedge clk);
        #1;
    endtask

    // Reset held for two cycles with an active slot-0 bit on the inputs;
    // reset must win and every output must read zero.
    task automatic test_reset();
        rst = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1);
        testsRun++;
        if (bus.ch !== 4'b0000) begin
            failCount++;
            $display("[TB] FAIL reset_ch: got %b expected %b", bus.ch, 4'b0000);
        end
        testsRun++;
        if (bus.ch_strobe !== 4'b0000) begin
            failCount++;
            $display("[TB] FAIL reset_strobe: got %b expected %b", bus.ch_strobe, 4'b0000);
        end
        testsRun++;
        if (bus.word !== 4'b0000) begin
            failCount++;
            $display("[TB] FAIL reset_word: got %b expected %b", bus.word, 4'b0000);
        end
        testsRun++;
        if (bus.frame_done !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL reset_frame_done: got %b expected 0", bus.frame_done);
        end
        testsRun++;
        if (bus.sync_err !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL reset_sync_err: got %b expected 0", bus.sync_err);
        end
    endtask

    // Frame 1,0,1,1 starting on the very first cycle after reset release.
    task automatic test_normal_frame();
        logic [3:0] bits;
        logic [3:0] expCh;
        logic [3:0] expStrobe;
        logic [3:0] expWord;
        bits  = 4'b1101;
        expCh = 4'b0000;
        rst   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, (i == 0), bits[i]);
            expCh[i]  = bits[i];
            expStrobe = 4'b0001 << i;
            expWord   = (i == 3) ? 4'b1101 : 4'b0000;
            testsRun++;
            if (bus.ch_strobe !== expStrobe) begin
                failCount++;
                $display("[TB] FAIL normal_strobe[%0d]: got %b expected %b", i, bus.ch_strobe, expStrobe);
            end
            testsRun++;
            if (bus.ch !== expCh) begin
                failCount++;
                $display("[TB] FAIL normal_ch[%0d]: got %b expected %b", i, bus.ch, expCh);
            end
            testsRun++;
            if (bus.frame_done !== (i == 3)) begin
                failCount++;
                $display("[TB] FAIL normal_frame_done[%0d]: got %b expected %b", i, bus.frame_done, (i == 3));
            end
            testsRun++;
            if (bus.word !== expWord) begin
                failCount++;
                $display("[TB] FAIL normal_word[%0d]: got %b expected %b", i, bus.word, expWord);
            end
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
        testsRun++;
        if (bus.ch_strobe !== 4'b0000 || bus.frame_done !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL normal_idle_pulses: got strobe=%b done=%b expected 0000/0", bus.ch_strobe, bus.frame_done);
        end
    endtask

    // Frames 1,0,1,0 then 0,1,0,1 with no gap: word 0101 then 1010, and the
    // two frame_done pulses exactly four cycles apart.
    task automatic test_back_to_back();
        logic [3:0] frameA;
        logic [3:0] frameB;
        logic [3:0] bits;
        logic [3:0] expStrobe;
        logic [3:0] expWord;
        int firstDone;
        int secondDone;
        frameA     = 4'b0101;
        frameB     = 4'b1010;
        firstDone  = -1;
        secondDone = -1;
        for (int i = 0; i < 8; i++) begin
            bits = (i < 4) ? frameA : frameB;
            applyStimulus(1'b1, (i % 4 == 0), bits[i % 4]);
            expStrobe = 4'b0001 << (i % 4);
            expWord   = (i < 3) ? 4'b1101 : ((i < 7) ? 4'b0101 : 4'b1010);
            if (bus.frame_done === 1'b1) begin
                if (firstDone < 0) firstDone = i;
                else secondDone = i;
            end
            testsRun++;
            if (bus.ch_strobe !== expStrobe) begin
                failCount++;
                $display("[TB] FAIL b2b_strobe[%0d]: got %b expected %b", i, bus.ch_strobe, expStrobe);
            end
            testsRun++;
            if (bus.word !== expWord) begin
                failCount++;
                $display("[TB] FAIL b2b_word[%0d]: got %b expected %b", i, bus.word, expWord);
            end
            testsRun++;
            if (bus.sync_err !== 1'b0) begin
                failCount++;
                $display("[TB] FAIL b2b_sync_err[%0d]: got %b expected 0", i, bus.sync_err);
            end
        end
        testsRun++;
        if (secondDone - firstDone !== 4 || firstDone !== 3) begin
            failCount++;
            $display("[TB] FAIL b2b_done_spacing: got first=%0d second=%0d expected 3 and 7", firstDone, secondDone);
        end
    endtask

    // Frame 1,0,1,1 with two invalid cycles between slots 1 and 2; the gap
    // cycles also carry frame_start, which must be ignored without din_valid.
    task automatic test_gapped();
        logic       vs   [6];
        logic       fss  [6];
        logic       ds   [6];
        logic [3:0] expStrobe [6];
        logic [3:0] expWord;
        vs        = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        fss       = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        ds        = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        expStrobe = '{4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0100, 4'b1000};
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vs[i], fss[i], ds[i]);
            expWord = (i == 5) ? 4'b1101 : 4'b1010;
            testsRun++;
            if (bus.ch_strobe !== expStrobe[i]) begin
                failCount++;
                $display("[TB] FAIL gap_strobe[%0d]: got %b expected %b", i, bus.ch_strobe, expStrobe[i]);
            end
            testsRun++;
            if (bus.sync_err !== 1'b0 || bus.frame_done !== (i == 5)) begin
                failCount++;
                $display("[TB] FAIL gap_pulses[%0d]: got sync=%b done=%b expected 0/%b", i, bus.sync_err, bus.frame_done, (i == 5));
            end
            testsRun++;
            if (bus.word !== expWord) begin
                failCount++;
                $display("[TB] FAIL gap_word[%0d]: got %b expected %b", i, bus.word, expWord);
            end
        end
    endtask

    // After reset, three valid bits without frame_start are dropped; the
    // following frame 0,1,1,0 yields word 0110.
    task automatic test_hunt_discard();
        logic [3:0] bits;
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1);
            testsRun++;
            if (bus.ch !== 4'b0000 || bus.ch_strobe !== 4'b0000) begin
                failCount++;
                $display("[TB] FAIL hunt_discard[%0d]: got ch=%b strobe=%b expected 0000/0000", i, bus.ch, bus.ch_strobe);
            end
        end
        bits = 4'b0110;
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, (i == 0), bits[i]);
        testsRun++;
        if (bus.word !== 4'b0110 || bus.frame_done !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL hunt_frame: got word=%b done=%b expected 0110/1", bus.word, bus.frame_done);
        end
    endtask

    // Slots 0,1 of a frame, then frame_start at slot 2: sync_err pulses, the
    // bit restarts at slot 0, old word kept; 1,1,1 then completes 1111.
    task automatic test_resync();
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        testsRun++;
        if (bus.sync_err !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL resync_sync_err: got %b expected 1", bus.sync_err);
        end
        testsRun++;
        if (bus.ch_strobe !== 4'b0001 || bus.ch !== 4'b0101) begin
            failCount++;
            $display("[TB] FAIL resync_ch: got strobe=%b ch=%b expected 0001/0101", bus.ch_strobe, bus.ch);
        end
        testsRun++;
        if (bus.word !== 4'b0110 || bus.frame_done !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL resync_word: got word=%b done=%b expected 0110/0", bus.word, bus.frame_done);
        end
        applyStimulus(1'b1, 1'b0, 1'b1);
        testsRun++;
        if (bus.sync_err !== 1'b0 || bus.ch_strobe !== 4'b0010) begin
            failCount++;
            $display("[TB] FAIL resync_slot1: got sync=%b strobe=%b expected 0/0010", bus.sync_err, bus.ch_strobe);
        end
        applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        testsRun++;
        if (bus.word !== 4'b1111 || bus.frame_done !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL resync_frame: got word=%b done=%b expected 1111/1", bus.word, bus.frame_done);
        end
    endtask

    // Reset after slot 1: all outputs clear, no frame_done, the state is
    // back in HUNT (untagged bit dropped), and frame 0,0,1,0 then works.
    task automatic test_reset_mid_frame();
        logic [3:0] bits;
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b1);
        testsRun++;
        if (bus.ch !== 4'b0000 || bus.word !== 4'b0000 || bus.ch_strobe !== 4'b0000) begin
            failCount++;
            $display("[TB] FAIL midrst_outputs: got ch=%b word=%b strobe=%b expected all 0000", bus.ch, bus.word, bus.ch_strobe);
        end
        testsRun++;
        if (bus.frame_done !== 1'b0 || bus.sync_err !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL midrst_pulses: got done=%b sync=%b expected 0/0", bus.frame_done, bus.sync_err);
        end
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b1);
        testsRun++;
        if (bus.ch_strobe !== 4'b0000 || bus.frame_done !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL midrst_hunt: got strobe=%b done=%b expected 0000/0", bus.ch_strobe, bus.frame_done);
        end
        bits = 4'b0100;
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, (i == 0), bits[i]);
        testsRun++;
        if (bus.word !== 4'b0100 || bus.ch !== 4'b0100 || bus.frame_done !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL midrst_frame: got word=%b ch=%b done=%b expected 0100/0100/1", bus.word, bus.ch, bus.frame_done);
        end
    endtask

    initial begin
        rst             = 1'b1;
        bus.din         = 1'b0;
        bus.din_valid   = 1'b0;
        bus.frame_start = 1'b0;
        test_reset();
        test_normal_frame();
        test_back_to_back();
        test_gapped();
        test_hunt_discard();
        test_resync();
        test_reset_mid_frame();
        applyStimulus(1'b0, 1'b0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
